// File: rtl/mod4_mul_signed.sv
// mod4_mul_signed
//   Two-stage pipelined Q2.14 signed multiplier. It joins the A stream (adder
//   output, with overflow flag) and the B stream (coefficient). S1 holds the
//   full-precision Q4.28 product. S2 holds the result after rounding
//   (half-up toward +inf) and saturation back to Q2.14. A 16-bit saturating
//   counter records how many results were clipped.
//
// Ports
//   clk               in   clock, rising edge
//   reset             in   asynchronous, active-high
//   input_tdata_a     in   [15:0] Q2.14 operand A
//   input_overflow_a  in   overflow flag for A, qualified by input_tvalid_a
//   input_tvalid_a    in   A beat valid
//   input_tready_a    out  A beat accepted (same as input_tready_b)
//   input_tdata_b     in   [15:0] Q2.14 operand B
//   input_tvalid_b    in   B beat valid
//   input_tready_b    out  B beat accepted
//   output_tdata      out  [15:0] rounded, saturated product
//   output_overflow   out  saturated here or upstream overflow
//   output_tvalid     out  output beat valid
//   output_tready     in   downstream accepts beat
//   sat_count         out  [15:0] saturating count of saturated results
//   sat_count_clr     in   synchronous clear of sat_count (wins over increment)

module mod4_mul_signed (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] input_tdata_a,
  input  logic        input_overflow_a,
  input  logic        input_tvalid_a,
  output logic        input_tready_a,
  input  logic [15:0] input_tdata_b,
  input  logic        input_tvalid_b,
  output logic        input_tready_b,
  output logic [15:0] output_tdata,
  output logic        output_overflow,
  output logic        output_tvalid,
  input  logic        output_tready,
  output logic [15:0] sat_count,
  input  logic        sat_count_clr
);

  logic               v1_q;
  logic               v2_q;
  logic signed [31:0] p1_q;
  logic               of1_q;
  logic [15:0]        data_q;
  logic               ovf_q;
  logic [15:0]        sat_cnt_q;

  logic               adv1;
  logic               adv2;
  logic               accept;
  logic signed [31:0] a_ext;
  logic signed [31:0] b_ext;
  logic signed [31:0] prod_d;
  logic signed [32:0] p1_ext;
  logic signed [32:0] round_sum;
  logic signed [18:0] r;
  logic               sat_hi;
  logic               sat_lo;
  logic               sat;
  logic [15:0]        result_d;
  logic               sat_inc;

  assign adv2   = !v2_q || output_tready;
  assign adv1   = !v1_q || adv2;
  // Both streams move together, and nothing is accepted while reset is held.
  assign accept = input_tvalid_a && input_tvalid_b && adv1 && !reset;

  assign input_tready_a = accept;
  assign input_tready_b = accept;

  assign a_ext  = $signed({{16{input_tdata_a[15]}}, input_tdata_a});
  assign b_ext  = $signed({{16{input_tdata_b[15]}}, input_tdata_b});
  assign prod_d = a_ext * b_ext;

  // Add half an LSB of the Q2.14 result, then shift arithmetically. This
  // rounds toward +inf on ties. After the shift the value fits in 19 bits.
  assign p1_ext    = $signed({p1_q[31], p1_q});
  assign round_sum = p1_ext + 33'sd8192;
  assign r         = 19'(round_sum >>> 14);

  assign sat_hi = (r > 19'sd32767);
  assign sat_lo = (r < -19'sd32768);
  assign sat    = sat_hi || sat_lo;

  always_comb begin
    result_d = r[15:0];
    if (sat_hi) begin
      result_d = 16'h7FFF;
    end else if (sat_lo) begin
      result_d = 16'h8000;
    end
  end

  assign sat_inc = adv2 && v1_q && sat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q  <= 1'b0;
      p1_q  <= '0;
      of1_q <= 1'b0;
    end else if (adv1) begin
      v1_q <= accept;
      if (accept) begin
        p1_q  <= prod_d;
        of1_q <= input_overflow_a;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2_q   <= 1'b0;
      data_q <= '0;
      ovf_q  <= 1'b0;
    end else if (adv2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        data_q <= result_d;
        ovf_q  <= sat || of1_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_cnt_q <= '0;
    end else if (sat_count_clr) begin
      sat_cnt_q <= '0;
    end else if (sat_inc && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end

  assign output_tdata    = data_q;
  assign output_overflow = ovf_q;
  assign output_tvalid   = v2_q;
  assign sat_count       = sat_cnt_q;

endmodule
